// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit.
//   - Branch-code constants for the 4-bit ex_branch field.
//   - 2-bit BHT counter encodings and the counter reset value.
//   - Flush FSM state type.
package branch_pkg;

  // Branch codes; any code with bit 3 clear is not a branch.
  localparam logic [3:0] BR_JMP = 4'b1000;
  localparam logic [3:0] BR_JZ  = 4'b1001;
  localparam logic [3:0] BR_JN  = 4'b1010;
  localparam logic [3:0] BR_JC  = 4'b1011;
  localparam logic [3:0] BR_RSV = 4'b1100;  // reserved: never taken, not a branch
  localparam logic [3:0] BR_JNZ = 4'b1101;
  localparam logic [3:0] BR_JNN = 4'b1110;
  localparam logic [3:0] BR_JNC = 4'b1111;

  // Saturating counter states; bit 1 is the prediction.
  localparam logic [1:0] CNT_SNT   = 2'b00;  // strongly not-taken
  localparam logic [1:0] CNT_WNT   = 2'b01;  // weakly not-taken
  localparam logic [1:0] CNT_WT    = 2'b10;  // weakly taken
  localparam logic [1:0] CNT_ST    = 2'b11;  // strongly taken
  localparam logic [1:0] BHT_RESET = CNT_WNT;

  typedef enum logic {
    StIdle,
    StFlush
  } flush_state_e;

endpackage

// File: rtl/bht_2bit.sv
// Direct-mapped branch history table of 2-bit saturating counters.
//   clk_i, rst_i : clock, synchronous active-high reset (all entries -> BHT_RESET)
//   rd_idx_i     : read index; rd_cnt_o is the stored counter (no write bypass)
//   wr_en_i      : update the entry at wr_idx_i
//   wr_taken_i   : direction of the resolved branch (+1 if taken, -1 if not)
module bht_2bit
  import branch_pkg::*;
#(
  parameter int unsigned Depth = 16,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic [1:0]      rd_cnt_o,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic            wr_taken_i
);

  logic [1:0] cnt_q [Depth];
  logic [1:0] wr_cur;
  logic [1:0] wr_nxt;

  // Read returns the registered value, so a same-cycle update is not visible.
  assign rd_cnt_o = cnt_q[rd_idx_i];
  assign wr_cur   = cnt_q[wr_idx_i];

  always_comb begin
    wr_nxt = wr_cur;
    if (wr_taken_i) begin
      if (wr_cur != CNT_ST) wr_nxt = wr_cur + 2'd1;
    end else begin
      if (wr_cur != CNT_SNT) wr_nxt = wr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        cnt_q[i] <= BHT_RESET;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_nxt;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution and prediction unit.
//   Fetch side : fetch_valid/fetch_is_branch/fetch_pc -> pred_taken (combinational, BHT bit 1)
//   Execute    : ex_valid/ex_branch/ex_pc/ex_target/ex_pred_taken -> jump (combinational)
//   Flags      : flags_we with z_in/n_in/c_in writes the {Z,N,C} register; bypassed same cycle
//   Redirect   : mispredict/redirect_pc registered one-cycle pulse; flush held FLUSH_CYC cycles
//   clk, rst   : single clock, synchronous active-high reset
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic              fetch_is_branch,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [3:0]        ex_branch,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic              flags_we,
  input  logic              z_in,
  input  logic              n_in,
  input  logic              c_in,
  output logic [2:0]        flags,
  output logic              jump,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);
  localparam int unsigned CntW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  // Codes counted as branches: JMP, JZ/JN/JC, JNZ/JNN/JNC (not 0xxx, not reserved).
  function automatic logic is_branch(input logic [3:0] code);
    return code[3] && (code != BR_RSV);
  endfunction

  // f = {Z,N,C}
  function automatic logic cond_taken(input logic [3:0] code, input logic [2:0] f);
    logic t;
    t = 1'b0;
    case (code)
      BR_JMP:  t = 1'b1;
      BR_JZ:   t = f[2];
      BR_JN:   t = f[1];
      BR_JC:   t = f[0];
      BR_JNZ:  t = ~f[2];
      BR_JNN:  t = ~f[1];
      BR_JNC:  t = ~f[0];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic [2:0]        flags_q;
  logic [2:0]        eff_flags;
  logic              ex_active;
  logic              br_valid;
  logic              mis_now;
  logic [ADDR_W-1:0] redirect_d;
  logic              mispredict_q;
  logic [ADDR_W-1:0] redirect_q;
  flush_state_e      state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        rd_cnt;

  // Flag register with same-cycle write bypass into condition evaluation.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else if (flags_we) begin
      flags_q <= {z_in, n_in, c_in};
    end
  end

  assign eff_flags = flags_we ? {z_in, n_in, c_in} : flags_q;
  assign flags     = flags_q;

  // The execute instruction is squashed while a flush is in progress.
  assign flush      = (state_q == StFlush);
  assign ex_active  = ex_valid & ~flush;
  assign br_valid   = ex_active & is_branch(ex_branch);
  assign jump       = ex_active & cond_taken(ex_branch, eff_flags);
  assign mis_now    = br_valid & (jump != ex_pred_taken);
  assign redirect_d = jump ? ex_target : ex_pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= mis_now;
      if (mis_now) redirect_q <= redirect_d;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;

  // Flush FSM: counter holds the remaining flush cycles after the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mis_now) begin
          state_d = StFlush;
          cnt_d   = CntW'(FLUSH_CYC - 1);
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  bht_2bit #(
    .Depth(BHT_DEPTH)
  ) u_bht (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_idx_i  (fetch_pc[IdxW-1:0]),
    .rd_cnt_o  (rd_cnt),
    .wr_en_i   (br_valid),
    .wr_idx_i  (ex_pc[IdxW-1:0]),
    .wr_taken_i(jump)
  );

  assign pred_taken = fetch_valid & fetch_is_branch & rd_cnt[1];

  // Upper fetch PC bits and the counter LSB do not affect the prediction.
  logic unused_bits;
  assign unused_bits = ^{fetch_pc, rd_cnt[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_is_branch;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [3:0]  ex_branch;
  logic [15:0] ex_pc, ex_target;
  logic        ex_pred_taken;
  logic        flags_we, z_in, n_in, c_in;
  logic [2:0]  flags;
  logic        jump, mispredict, flush;
  logic [15:0] redirect_pc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .ADDR_W   (16),
    .BHT_DEPTH(4),
    .FLUSH_CYC(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .fetch_is_branch(fetch_is_branch),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .flags_we       (flags_we),
    .z_in           (z_in),
    .n_in           (n_in),
    .c_in           (c_in),
    .flags          (flags),
    .jump           (jump),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; registered outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    ex_valid      = 1'b0;
    ex_branch     = 4'b0000;
    ex_pred_taken = 1'b0;
    flags_we      = 1'b0;
  endtask

  task automatic issue(input logic [3:0] code, input logic [15:0] pc, input logic [15:0] tgt,
                       input logic pred);
    ex_valid      = 1'b1;
    ex_branch     = code;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
    #1;
  endtask

  task automatic set_flags(input logic z, input logic n, input logic c);
    flags_we = 1'b1;
    z_in = z;
    n_in = n;
    c_in = c;
  endtask

  task automatic fetch_at(input logic [15:0] pc);
    fetch_pc = pc;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fetch_valid = 1'b1; fetch_is_branch = 1'b1; fetch_pc = 16'h0005;
    ex_valid = 1'b0; ex_branch = 4'b0000; ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0;
    flags_we = 1'b0; z_in = 1'b0; n_in = 1'b0; c_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_mispredict", 32'(mispredict), 32'h0);
    check("rst_redirect", 32'(redirect_pc), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_pred", 32'(pred_taken), 32'h0);

    // Z=1 in the register, visible one cycle later.
    set_flags(1'b1, 1'b0, 1'b0);
    step();
    check("flags_written", 32'(flags), 32'h4);

    // Train entry 1 (pc 5) with taken JZ; counter 01 -> 10 -> 11 -> 11.
    issue(BR_JZ, 16'h0005, 16'h0020, 1'b1);
    check("jz_jump", 32'(jump), 32'h1);
    check("pred_old_same_cycle", 32'(pred_taken), 32'h0);
    step();
    check("jz_no_mispredict", 32'(mispredict), 32'h0);
    issue(BR_JZ, 16'h0005, 16'h0020, 1'b1);
    step();
    check("pred_after_two", 32'(pred_taken), 32'h1);
    fetch_at(16'h0001);
    check("pred_alias_pc1", 32'(pred_taken), 32'h1);
    fetch_at(16'h0006);
    check("pred_other_entry", 32'(pred_taken), 32'h0);
    fetch_at(16'h0005);
    issue(BR_JZ, 16'h0005, 16'h0020, 1'b1);
    step();
    // Two not-taken steps from a saturated 11: 10 (still taken) then 01.
    issue(BR_JNZ, 16'h0005, 16'h0020, 1'b0);
    check("jnz_not_taken", 32'(jump), 32'h0);
    step();
    check("pred_sat_11_dec", 32'(pred_taken), 32'h1);
    issue(BR_JNZ, 16'h0001, 16'h0020, 1'b0);  // aliases onto entry 1
    step();
    check("pred_alias_dec", 32'(pred_taken), 32'h0);

    // Same-cycle fetch sees the pre-update counter.
    issue(BR_JZ, 16'h0005, 16'h0020, 1'b1);
    check("pred_no_bypass", 32'(pred_taken), 32'h0);
    step();
    check("pred_after_update", 32'(pred_taken), 32'h1);
    fetch_is_branch = 1'b0;
    #1;
    check("pred_gated_nonbranch", 32'(pred_taken), 32'h0);
    fetch_is_branch = 1'b1;

    // Flag bypass: register Z=0, write Z=1 in the same cycle as JNZ.
    set_flags(1'b0, 1'b0, 1'b0);
    step();
    check("flags_cleared", 32'(flags), 32'h0);
    set_flags(1'b1, 1'b0, 1'b0);
    issue(BR_JNZ, 16'h1234, 16'h0ABC, 1'b1);
    check("bypass_jump", 32'(jump), 32'h0);
    step();
    check("bypass_mispredict", 32'(mispredict), 32'h1);
    check("bypass_redirect", 32'(redirect_pc), 32'h1235);
    check("bypass_flush1", 32'(flush), 32'h1);
    check("bypass_flags", 32'(flags), 32'h4);
    step();
    check("bypass_mis_pulse", 32'(mispredict), 32'h0);
    check("bypass_flush2", 32'(flush), 32'h1);
    step();
    check("bypass_flush_end", 32'(flush), 32'h0);

    // Fall-through redirect wraps at the top of the address space.
    issue(BR_JNZ, 16'hFFFF, 16'h0012, 1'b1);
    step();
    check("wrap_mispredict", 32'(mispredict), 32'h1);
    check("wrap_redirect", 32'(redirect_pc), 32'h0000);
    step();
    step();
    check("wrap_flush_end", 32'(flush), 32'h0);

    // JMP predicted not-taken; branches injected during the flush are ignored.
    issue(BR_JMP, 16'h0100, 16'h0040, 1'b0);
    check("jmp_jump", 32'(jump), 32'h1);
    step();
    check("jmp_mispredict", 32'(mispredict), 32'h1);
    check("jmp_redirect", 32'(redirect_pc), 32'h0040);
    check("jmp_flush1", 32'(flush), 32'h1);
    issue(BR_JZ, 16'h0006, 16'h0077, 1'b0);
    check("flush_jump1", 32'(jump), 32'h0);
    step();
    check("flush_no_second_mis", 32'(mispredict), 32'h0);
    check("jmp_flush2", 32'(flush), 32'h1);
    issue(BR_JZ, 16'h0006, 16'h0077, 1'b0);
    check("flush_jump2", 32'(jump), 32'h0);
    step();
    check("flush_mis_after", 32'(mispredict), 32'h0);
    check("jmp_flush_end", 32'(flush), 32'h0);
    fetch_at(16'h0006);
    check("flush_bht_unchanged", 32'(pred_taken), 32'h0);

    // Non-branch and reserved codes never jump or mispredict.
    issue(4'b0000, 16'h0006, 16'h0055, 1'b1);
    check("code0000_jump", 32'(jump), 32'h0);
    step();
    check("code0000_mis", 32'(mispredict), 32'h0);
    issue(BR_RSV, 16'h0006, 16'h0055, 1'b1);
    check("code1100_jump", 32'(jump), 32'h0);
    step();
    check("code1100_mis", 32'(mispredict), 32'h0);
    check("code1100_flush", 32'(flush), 32'h0);

    // Reset in the first flush cycle.
    set_flags(1'b0, 1'b1, 1'b1);
    step();
    check("flags_nc", 32'(flags), 32'h3);
    issue(BR_JMP, 16'h0006, 16'h0080, 1'b0);
    step();
    check("pre_rst_flush", 32'(flush), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_flush", 32'(flush), 32'h0);
    check("midrst_flags", 32'(flags), 32'h0);
    check("midrst_mispredict", 32'(mispredict), 32'h0);
    check("midrst_redirect", 32'(redirect_pc), 32'h0);
    for (int i = 0; i < 4; i++) begin
      fetch_at(16'(i));
      check($sformatf("midrst_pred%0d", i), 32'(pred_taken), 32'h0);
    end
    // One taken update from 01 must reach 10.
    for (int i = 0; i < 4; i++) begin
      issue(BR_JMP, 16'(i), 16'h0090, 1'b1);
      step();
      fetch_at(16'(i));
      check($sformatf("midrst_inc%0d", i), 32'(pred_taken), 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and prediction unit for the MIPS-style pipeline. It extends plain jump decision with:
- a registered flag file;
- negated condition codes;
- a direct-mapped branch history table (BHT) of 2-bit saturating counters for fetch-stage prediction;
- execute-stage misprediction detection with a timed pipeline flush.

It sits between fetch (prediction) and execute (resolution) and drives the PC-redirect mux.

## Interface
- `ADDR_W`, 16, PC width in words.
- `BHT_DEPTH`, 16, number of BHT entries; must be a power of two, at least 2.
- `FLUSH_CYC`, 2, cycles `flush` stays high after a mispredict; must be at least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_valid`  in  1  fetch-stage instruction valid.
- `fetch_is_branch`  in  1  fetch instruction decodes as a branch.
- `fetch_pc`  in  ADDR_W  fetch PC.
- `pred_taken`  out  1  combinational prediction for the fetch instruction.
- `ex_valid`  in  1  execute-stage instruction valid.
- `ex_branch`  in  4  branch code (see Operation).
- `ex_pc`  in  ADDR_W  execute PC.
- `ex_target`  in  ADDR_W  resolved branch target.
- `ex_pred_taken`  in  1  prediction carried down the pipe with this instruction.
- `flags_we`  in  1  write Z/N/C this cycle.
- `z_in`, `n_in`, `c_in`  in  1 each  new flag values.
- `flags`  out  3  registered {Z,N,C}.
- `jump`  out  1  combinational resolved-taken for the execute instruction.
- `mispredict`  out  1  registered, one-cycle pulse.
- `redirect_pc`  out  ADDR_W  registered; valid while `mispredict` is high.
- `flush`  out  1  registered; squash younger stages.

## Operation
- Branch codes for `ex_branch`:
  - 0xxx: not a branch.
  - 1000: JMP, always taken.
  - 1001 / 1010 / 1011: JZ / JN / JC, taken when the flag is 1.
  - 1101 / 1110 / 1111: JNZ / JNN / JNC, taken when the flag is 0.
  - 1100: reserved, never taken, not counted as a branch.
- Effective flags: when `flags_we` is high, use `z_in`/`n_in`/`c_in` (bypass); otherwise use the `flags` register. The register updates at the edge after `flags_we`.
- `jump = ex_active & taken(ex_branch, effective flags)`, where `ex_active = ex_valid & !flush`.
- BHT:
  - Entry index is `pc[log2(BHT_DEPTH)-1:0]`; counters are 2 bits.
  - `pred_taken = fetch_valid & fetch_is_branch & counter[1]`.
  - On each `ex_active` valid branch (codes 1000, 1001–1011, 1101–1111), the entry for `ex_pc` saturates: +1 if taken, −1 if not (00 and 11 hold).
- Mispredict:
  - Occurs when `ex_active` and the branch is valid and `jump != ex_pred_taken`.
  - `redirect_pc` is `ex_target` when `jump` is high, otherwise `ex_pc + 1` (wraps modulo 2^ADDR_W).
  - Non-branch codes never mispredict, even if `ex_pred_taken` is high.
- Flush FSM:
  - IDLE → FLUSH on mispredict; load a down-counter with `FLUSH_CYC-1`.
  - FLUSH holds `flush = 1` and decrements the counter; return to IDLE when it reaches 0.
  - While in FLUSH, `ex_valid` is ignored: no jump, no BHT update, no new mispredict.
  - `flags_we` is still honoured during FLUSH.
- Reset values:
  - `flags = 000`, `mispredict = 0`, `redirect_pc = 0`, `flush = 0`, FSM = IDLE.
  - All BHT counters = 01 (weakly not-taken).
  - Reset mid-flush terminates the flush the next cycle.
  - Reset has priority over every other input.

## Timing
- `pred_taken` and `jump`: combinational, same cycle as their inputs.
- `mispredict` / `redirect_pc`: high in cycle E+1 for a resolution in cycle E.
- `flush`: high in cycles E+1 … E+FLUSH_CYC.
- The earliest next accepted `ex_valid` is cycle E+FLUSH_CYC+1.
- BHT write takes effect at the edge ending cycle E. A fetch read of the same index in cycle E sees the old value (no bypass).
- `flags` is visible one cycle after `flags_we`.

## Structure
- Shared package `branch_pkg`:
  - Branch-code constants: `BR_JMP`, `BR_JZ`, `BR_JN`, `BR_JC`, `BR_JNZ`, `BR_JNN`, `BR_JNC`.
  - Counter-encoding constants, and `BHT_RESET = 2'b01`.
  - Flush FSM state encoding (IDLE, FLUSH).
- Sub-module `bht_2bit`: counter array with one read port and one write port, parametrised by depth. Holds the saturating-update logic and reset initialisation.
- The condition-evaluation function lives in the top level.

## Test plan
- Reset, then fetch PC 0x0005 with `fetch_is_branch = 1` → `pred_taken = 0`. After two taken JZ resolutions at `ex_pc = 0x0005` (Z = 1), the same fetch → `pred_taken = 1`. A third taken resolution leaves the counter at 11.
- Bypass:
  - `flags_we = 1`, `z_in = 1`, JNZ in the same cycle with `ex_pred_taken = 1` → `jump = 0`, `mispredict` pulses next cycle, `redirect_pc = ex_pc + 1`.
  - Wrap case: `ex_pc = 0xFFFF` → `redirect_pc = 0x0000`.
- Mispredict with `FLUSH_CYC = 2`: JMP, `ex_pred_taken = 0`, `ex_target = 0x0040` → `mispredict = 1` and `redirect_pc = 0x0040` for exactly one cycle. `flush = 1` for 2 cycles. A mispredicting `ex_valid` branch injected during the flush produces no jump, no BHT change and no second mispredict.
- Codes 0000 and 1100 with `ex_pred_taken = 1` → `jump = 0`, no mispredict, BHT unchanged.
- Assert `rst` in the first flush cycle → next cycle `flush = 0`, `flags = 000`, and every BHT entry reads 01.
- Aliasing with `BHT_DEPTH = 4`: updates to PC 0x0001 and 0x0005 hit the same entry. Fetch of 0x0005 in the same cycle as an update to 0x0005 returns the pre-update prediction.
